fp_result_fifo: RTL and testbench
=================================

FP_RESULT_FIFO -- requirements
Module: fp_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flag_i  input  1  result-valid strobe from the fp_13 FPU (its flag_o).
REQ-005 SHALL have port c_i  input  32  Float32 result from the FPU (its c).
REQ-006 SHALL have port clr_i  input  1  synchronous flush of contents and sticky error.
REQ-007 SHALL have port res_ready_i  input  1  consumer accepts head entry.
REQ-008 SHALL have port res_o  output  32  head-entry result, first-word-fall-through.
REQ-009 SHALL have port res_valid_o  output  1  head entry valid (FIFO non-empty).
REQ-010 SHALL have port class_o  output  4  head-entry class, one-hot {nan,inf,zero,denorm}; 0000 = normal.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port full_o  output  1  count_o == DEPTH.
REQ-013 SHALL have port ovf_o  output  1  sticky: a result was dropped.

Function
REQ-014 Push SHALL occur on a rising edge when flag_i=1 and (not full, or a pop occurs in the same cycle).
REQ-015 Pop SHALL occur on a rising edge when res_valid_o=1 and res_ready_i=1.
REQ-016 Pushed entry SHALL be visible on res_o/res_valid_o in the cycle after the push edge if the FIFO was empty (1-cycle latency).
REQ-017 res_o and class_o SHALL be driven from registered storage only, with no combinational path from c_i.
REQ-018 Simultaneous push and pop SHALL leave count_o unchanged, including when full, and SHALL lose no data.
REQ-019 flag_i=1 while full with no pop SHALL drop c_i, leave contents unchanged, and set ovf_o on that edge.
REQ-020 ovf_o SHALL remain set until rst or clr_i.
REQ-021 Pop while empty SHALL be ignored; res_o value is don't-care when res_valid_o=0.
REQ-022 Read/write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-023 clr_i=1 SHALL on the next edge set count to 0, reset both pointers, and clear ovf_o.
REQ-024 clr_i SHALL take priority over a simultaneous push/pop; that push is dropped and SHALL NOT set ovf_o.
REQ-025 Class SHALL be computed at push time from c_i and stored per entry: exp=FF with mant!=0 is nan; exp=FF with mant=0 is inf; exp=0 with mant=0 is zero (either sign); exp=0 with mant!=0 is denorm.

Reset
REQ-026 rst SHALL asynchronously clear pointers, count_o, ovf_o, and full_o to 0, and res_valid_o to 0.
REQ-027 Data storage SHALL NOT require reset; res_o SHALL read 32'h0 while empty after reset.
REQ-028 rst asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL be treated as entry 0.

Configuration
REQ-029 Macro FP_RESULT_CLASSIFY_EN defined: class storage and decode SHALL be included per REQ-025.
REQ-030 Macro FP_RESULT_CLASSIFY_EN undefined: class_o SHALL remain a port tied to 4'b0000, with no class storage; all other behaviour SHALL be identical.

Verification
REQ-031 Push c_i=32'h40400000 for one cycle -> the next cycle shows res_valid_o=1, res_o=32'h40400000, count_o=1; pop -> count_o=0.
REQ-032 Push 32'h40200000, 32'h3f000000, 32'h40000000, 32'h39d6f545 with no pops, then a 5th push of 32'h3a007358 -> full_o=1, ovf_o=1, and pops return the first four in order.
REQ-033 With the FIFO full, push 32'h3f800000 while res_ready_i=1 -> count_o stays 4, ovf_o=0, and the new value is popped last.
REQ-034 With classification enabled, push 32'h7fc00000, 32'hff800000, 32'h80000000, 32'h00000001, 32'h3fc00000 -> class_o reads 1000, 0100, 0010, 0001, 0000 in order.
REQ-035 With 3 entries and ovf_o=1, assert clr_i together with flag_i -> next cycle count_o=0, ovf_o=0, res_valid_o=0.
REQ-036 Assert rst asynchronously mid-stream with 2 entries -> outputs clear immediately; after release, push 32'h41700000 -> it is the head entry.

Source files
------------

// File: rtl/fp_result_fifo.sv
// Result FIFO behind the FPU: buffers flag_i/c_i results, first-word-fall-through head.
// Optional per-entry class decode enabled by defining FP_RESULT_CLASSIFY_EN.
module fp_result_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flag_i,
    input  logic [31:0]              c_i,
    input  logic                     clr_i,
    input  logic                     res_ready_i,
    output logic [31:0]              res_o,
    output logic                     res_valid_o,
    output logic [3:0]               class_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     ovf_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop;
    logic          push;
    logic          drop;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        pop  = res_valid_o && res_ready_i;
        push = flag_i && (!full_o || pop);
        drop = flag_i && full_o && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_o     <= '0;
            full_o      <= 1'b0;
            res_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else if (clr_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_o     <= '0;
            full_o      <= 1'b0;
            res_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) begin
                count_o     <= count_o + CW'(1);
                full_o      <= (count_o == CW'(DEPTH - 1));
                res_valid_o <= 1'b1;
            end else if (pop && !push) begin
                count_o     <= count_o - CW'(1);
                full_o      <= 1'b0;
                res_valid_o <= (count_o != CW'(1));
            end
            if (drop) ovf_o <= 1'b1;
        end
    end

    // Storage is intentionally unreset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !clr_i) data_mem[wr_ptr] <= c_i;
    end

    assign res_o = res_valid_o ? data_mem[rd_ptr] : 32'h0;

`ifdef FP_RESULT_CLASSIFY_EN
    logic [3:0] class_mem [DEPTH];
    logic [3:0] class_in;

    // One-hot {nan, inf, zero, denorm}; normal numbers encode as 0000.
    always_comb begin
        class_in = 4'b0000;
        if (c_i[30:23] == 8'hff) begin
            class_in = (c_i[22:0] != 23'h0) ? 4'b1000 : 4'b0100;
        end else if (c_i[30:23] == 8'h00) begin
            class_in = (c_i[22:0] == 23'h0) ? 4'b0010 : 4'b0001;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr_i) class_mem[wr_ptr] <= class_in;
    end

    assign class_o = res_valid_o ? class_mem[rd_ptr] : 4'b0000;
`else
    assign class_o = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_result_fifo.sv
// Scoreboard bench for fp_result_fifo: directed scenarios plus randomized traffic.
module tb_fp_result_fifo;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flag = 1'b0;
    logic [31:0] c = 32'h0;
    logic        clr = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] res;
    logic        res_valid;
    logic [3:0]  cls;
    logic [2:0]  count;
    logic        full;
    logic        ovf;

    int          tests = 0;
    int          fails = 0;
    logic [35:0] exp_q[$];
    bit          model_ovf = 1'b0;
    bit          mon_en = 1'b0;

    fp_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flag_i(flag), .c_i(c), .clr_i(clr),
        .res_ready_i(ready), .res_o(res), .res_valid_o(res_valid),
        .class_o(cls), .count_o(count), .full_o(full), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_class(input logic [31:0] v);
`ifdef FP_RESULT_CLASSIFY_EN
        int unsigned e = (v >> 23) & 32'hff;
        int unsigned m = v & 32'h7fffff;
        if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 0)   return (m == 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs to the model and retires the head on each handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", 32'(res_valid), 32'(exp_q.size() != 0));
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
            chk("ovf", 32'(ovf), 32'(model_ovf));
            if (exp_q.size() != 0) begin
                chk("data", res, exp_q[0][31:0]);
                chk("class", 32'(cls), 32'(exp_q[0][35:32]));
                if (ready && !clr) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; model bookkeeping happens right after the edge.
    task automatic cyc(input bit f, input logic [31:0] d, input bit r, input bit cl);
        int  sz;
        bit  p_pop;
        bit  p_push;
        flag  = f;
        c     = d;
        ready = r;
        clr   = cl;
        sz     = exp_q.size();
        p_pop  = (sz > 0) && r;
        p_push = f && ((sz < DEPTH) || p_pop);
        @(posedge clk);
        if (cl) begin
            exp_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (p_push) exp_q.push_back({exp_class(d), d});
            if (f && !p_push) model_ovf = 1'b1;
        end
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] fill [4];
        logic [31:0] cvec [5];
        fill = '{32'h40200000, 32'h3f000000, 32'h40000000, 32'h39d6f545};
        cvec = '{32'h7fc00000, 32'hff800000, 32'h80000000, 32'h00000001, 32'h3fc00000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_res", res, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single push then pop
        cyc(1, 32'h40400000, 0, 0);
        chk("t31_count", 32'(count), 32'd1);
        chk("t31_res", res, 32'h40400000);
        cyc(0, 32'h0, 1, 0);
        chk("t31_pop", 32'(count), 32'd0);

        // Fill, overflow, drain in order
        foreach (fill[i]) cyc(1, fill[i], 0, 0);
        cyc(1, 32'h3a007358, 0, 0);
        chk("t32_full", 32'(full), 32'd1);
        chk("t32_ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0);
        chk("t32_empty", 32'(res_valid), 32'd0);
        chk("t32_ovf_sticky", 32'(ovf), 32'd1);
        cyc(0, 32'h0, 0, 1);
        chk("clr_ovf", 32'(ovf), 32'd0);

        // Push and pop together while full
        foreach (fill[i]) cyc(1, fill[i], 0, 0);
        cyc(1, 32'h3f800000, 1, 0);
        chk("t33_count", 32'(count), 32'd4);
        chk("t33_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 1, 0);
        chk("t33_last", res, 32'h3f800000);
        cyc(0, 32'h0, 1, 0);

        // Class decode of special values
        for (int i = 0; i < 4; i++) cyc(1, cvec[i], 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0);
        cyc(1, cvec[4], 0, 0);
        cyc(0, 32'h0, 1, 0);

        // Clear beats a simultaneous push
        foreach (fill[i]) cyc(1, fill[i], 0, 0);
        cyc(1, 32'h12345678, 0, 0);
        cyc(0, 32'h0, 1, 0);
        chk("t35_pre_count", 32'(count), 32'd3);
        chk("t35_pre_ovf", 32'(ovf), 32'd1);
        cyc(1, 32'h3f800000, 0, 1);
        chk("t35_count", 32'(count), 32'd0);
        chk("t35_ovf", 32'(ovf), 32'd0);
        chk("t35_valid", 32'(res_valid), 32'd0);

        // Asynchronous reset mid-stream
        cyc(1, 32'h40a00000, 0, 0);
        cyc(1, 32'h40c00000, 0, 0);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t36_count", 32'(count), 32'd0);
        chk("t36_valid", 32'(res_valid), 32'd0);
        chk("t36_res", res, 32'h0);
        exp_q.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        cyc(1, 32'h41700000, 0, 0);
        chk("t36_head", res, 32'h41700000);
        cyc(0, 32'h0, 1, 0);

        // Randomized traffic with special-value bias
        for (int n = 0; n < 2000; n++) begin
            d = $urandom;
            case ($urandom_range(0, 5))
                0: d[30:23] = 8'hff;
                1: begin d[30:23] = 8'hff; d[22:0] = 23'h0; end
                2: d[30:23] = 8'h00;
                3: begin d[30:23] = 8'h00; d[22:0] = 23'h0; end
                default: ;
            endcase
            cyc($urandom_range(0, 9) < 6, d, $urandom_range(0, 1) == 1,
                $urandom_range(0, 49) == 0);
        end
        cyc(0, 32'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
